relu_maxpool: RTL and testbench

RELU_MAXPOOL -- requirements
Module: relu_maxpool

---
 rtl/relu_maxpool.sv | 111 +++++++++++
 tb/tb_relu_maxpool.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool.sv
// relu_maxpool: per-channel ReLU followed by 2x2 stride-2 max pooling
// over a raster-order pixel stream, one pooled pixel per completed window.
module relu_maxpool #(
    parameter int CO     = 3,
    parameter int I_F_BW = 23,
    parameter int IX     = 24,
    parameter int IY     = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic [CO*I_F_BW-1:0]   i_fmap,
    output logic                   o_valid,
    output logic [CO*I_F_BW-1:0]   o_fmap,
    output logic                   o_done
);

    localparam int FW = CO * I_F_BW;
    localparam int LN = IX / 2;
    localparam int XW = (IX > 1) ? $clog2(IX) : 1;
    localparam int YW = (IY > 1) ? $clog2(IY) : 1;
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [FW-1:0] hold_q;
    logic [FW-1:0] lb_q [LN];
    logic [FW-1:0] o_fmap_q;
    logic          o_valid_q;
    logic          o_done_q;

    logic [LW-1:0] lb_idx;
    logic [FW-1:0] lb_rd;
    logic [FW-1:0] relu_v;
    logic [FW-1:0] hmax_v;
    logic [FW-1:0] vmax_v;
    logic          x_last;
    logic          y_last;
    logic          fire;

    assign lb_idx = LW'(x_q >> 1);
    assign lb_rd  = lb_q[lb_idx];
    assign x_last = (x_q == XW'(IX - 1));
    assign y_last = (y_q == YW'(IY - 1));
    // An odd/odd beat closes a 2x2 window.
    assign fire   = i_valid & x_q[0] & y_q[0];

    for (genvar c = 0; c < CO; c++) begin : g_ch
        logic [I_F_BW-1:0] smp;
        logic [I_F_BW-1:0] rl;
        logic [I_F_BW-1:0] hd;
        logic [I_F_BW-1:0] hm;
        logic [I_F_BW-1:0] lb;
        assign smp = i_fmap[c*I_F_BW +: I_F_BW];
        assign rl  = smp[I_F_BW-1] ? '0 : smp;
        assign hd  = hold_q[c*I_F_BW +: I_F_BW];
        assign hm  = (rl > hd) ? rl : hd;
        assign lb  = lb_rd[c*I_F_BW +: I_F_BW];
        assign relu_v[c*I_F_BW +: I_F_BW] = rl;
        assign hmax_v[c*I_F_BW +: I_F_BW] = hm;
        // Post-ReLU values are non-negative, so unsigned compare is exact.
        assign vmax_v[c*I_F_BW +: I_F_BW] = (lb > hm) ? lb : hm;
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (i_valid) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            o_valid_q <= 1'b0;
            o_done_q  <= 1'b0;
            o_fmap_q  <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            o_valid_q <= fire;
            o_done_q  <= fire & x_last & y_last;
            if (fire) begin
                o_fmap_q <= vmax_v;
            end
        end
    end

    // Hold and line buffer are always written before being read.
    always_ff @(posedge clk) begin
        if (!reset && i_valid) begin
            if (!x_q[0]) begin
                hold_q <= relu_v;
            end else if (!y_q[0]) begin
                lb_q[lb_idx] <= hmax_v;
            end
        end
    end

    assign o_valid = o_valid_q;
    assign o_fmap  = o_fmap_q;
    assign o_done  = o_done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Bench for relu_maxpool: directed frames plus random data/gaps,
// checked against a window-level pooling model.
module tb_relu_maxpool;

    localparam int CO = 3;
    localparam int W  = 23;
    localparam int IX = 24;
    localparam int IY = 24;
    localparam int FW = CO * W;
    localparam int NP = (IX / 2) * (IY / 2);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_valid = 1'b0;
    logic [FW-1:0] i_fmap = '0;
    logic          o_valid;
    logic [FW-1:0] o_fmap;
    logic          o_done;

    relu_maxpool #(
        .CO(CO), .I_F_BW(W), .IX(IX), .IY(IY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_valid(i_valid),
        .i_fmap(i_fmap),
        .o_valid(o_valid),
        .o_fmap(o_fmap),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [FW-1:0] frm [IY][IX];

    logic [FW-1:0] exp_d[$];
    bit            exp_done[$];
    int            exp_c[$];
    logic [FW-1:0] obs_d[$];
    bit            obs_done[$];
    int            obs_c[$];

    int            hold_viol = 0;
    logic [FW-1:0] last_out = '0;

    int errs = 0;
    int checks = 0;

    always @(negedge clk) begin
        if (reset) begin
            last_out = '0;
        end else if (o_valid) begin
            obs_d.push_back(o_fmap);
            obs_done.push_back(o_done);
            obs_c.push_back(cyc);
            last_out = o_fmap;
        end else begin
            if (o_fmap !== last_out) hold_viol++;
            if (o_done !== 1'b0) hold_viol++;
        end
    end

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        i_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_q();
        exp_d.delete();
        exp_done.delete();
        exp_c.delete();
        obs_d.delete();
        obs_done.delete();
        obs_c.delete();
        hold_viol = 0;
    endtask

    task automatic fill_ramp();
        for (int y = 0; y < IY; y++)
            for (int x = 0; x < IX; x++)
                for (int c = 0; c < CO; c++)
                    frm[y][x][c*W +: W] = W'(y * IX + x);
    endtask

    task automatic fill_const(logic [W-1:0] v);
        for (int y = 0; y < IY; y++)
            for (int x = 0; x < IX; x++)
                for (int c = 0; c < CO; c++)
                    frm[y][x][c*W +: W] = v;
    endtask

    task automatic fill_rand();
        for (int y = 0; y < IY; y++)
            for (int x = 0; x < IX; x++)
                for (int c = 0; c < CO; c++)
                    frm[y][x][c*W +: W] = W'($urandom);
    endtask

    // Pooled pixel = max(0, four window samples) as signed integers.
    task automatic model_frame();
        logic [FW-1:0]       r;
        logic signed [W-1:0] sv;
        int                  m;
        int                  s;
        for (int py = 0; py < IY / 2; py++) begin
            for (int px = 0; px < IX / 2; px++) begin
                r = '0;
                for (int c = 0; c < CO; c++) begin
                    m = 0;
                    for (int dy = 0; dy < 2; dy++) begin
                        for (int dx = 0; dx < 2; dx++) begin
                            sv = frm[2*py+dy][2*px+dx][c*W +: W];
                            s = int'(sv);
                            if (s > m) m = s;
                        end
                    end
                    r[c*W +: W] = W'(m);
                end
                exp_d.push_back(r);
                exp_done.push_back(py == IY/2 - 1 && px == IX/2 - 1);
            end
        end
    endtask

    // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps
    task automatic drive_frame(int gap_mode);
        int g;
        for (int y = 0; y < IY; y++) begin
            for (int x = 0; x < IX; x++) begin
                i_valid = 1'b1;
                i_fmap  = frm[y][x];
                step();
                if ((x % 2) == 1 && (y % 2) == 1) exp_c.push_back(cyc);
                g = (gap_mode == 1) ? 1 :
                    (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                if (g > 0) idle(g);
            end
        end
    endtask

    task automatic check_frame(string tag);
        int n;
        chk({tag, "_count"}, 128'(obs_d.size()), 128'(exp_d.size()));
        chk({tag, "_lat_count"}, 128'(obs_c.size()), 128'(exp_c.size()));
        n = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), 128'(obs_d[i]), 128'(exp_d[i]));
            chk($sformatf("%s_done%0d", tag, i), 128'(obs_done[i]), 128'(exp_done[i]));
            if (i < exp_c.size())
                chk($sformatf("%s_lat%0d", tag, i), 128'(obs_c[i]), 128'(exp_c[i]));
        end
        chk({tag, "_hold"}, 128'(hold_viol), 128'(0));
    endtask

    initial begin
        logic [FW-1:0] first_win;
        // Reset state
        reset = 1'b1;
        repeat (3) step();
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_done", 128'(o_done), 128'(0));
        chk("rst_fmap", 128'(o_fmap), 128'(0));
        reset = 1'b0;
        idle(2);

        // Ramp frame, back-to-back
        clear_q();
        fill_ramp();
        model_frame();
        drive_frame(0);
        idle(4);
        check_frame("ramp");
        if (obs_d.size() == NP) begin
            chk("ramp_first", 128'(obs_d[0][W-1:0]), 128'(25));
            chk("ramp_second", 128'(obs_d[1][W-1:0]), 128'(27));
            chk("ramp_last", 128'(obs_d[NP-1][W-1:0]), 128'(575));
        end

        // All-negative frame
        clear_q();
        fill_const('1);
        model_frame();
        drive_frame(0);
        idle(4);
        check_frame("neg");

        // Mixed-sign window in a random frame
        clear_q();
        fill_rand();
        frm[0][0][0 +: W] = W'(-5);
        frm[0][1][0 +: W] = W'(3);
        frm[1][0][0 +: W] = W'(-7);
        frm[1][1][0 +: W] = W'(-1);
        frm[0][0][W +: W] = W'(-5);
        frm[0][1][W +: W] = W'(-3);
        frm[1][0][W +: W] = W'(-7);
        frm[1][1][W +: W] = W'(-1);
        model_frame();
        drive_frame(0);
        idle(4);
        check_frame("mixed");
        if (obs_d.size() > 0) begin
            first_win = obs_d[0];
            chk("mixed_ch0", 128'(first_win[0 +: W]), 128'(3));
            chk("mixed_ch1", 128'(first_win[W +: W]), 128'(0));
        end

        // Gapped ramp
        clear_q();
        fill_ramp();
        model_frame();
        drive_frame(1);
        idle(4);
        check_frame("gap");

        // Random data, random gaps
        clear_q();
        fill_rand();
        model_frame();
        drive_frame(2);
        idle(4);
        check_frame("rand");

        // Reset mid-frame after 100 beats
        fill_rand();
        for (int b = 0; b < 100; b++) begin
            i_valid = 1'b1;
            i_fmap  = frm[b / IX][b % IX];
            step();
        end
        reset   = 1'b1;
        i_valid = 1'b1;
        i_fmap  = '1;
        step();
        chk("midrst_valid", 128'(o_valid), 128'(0));
        chk("midrst_done", 128'(o_done), 128'(0));
        chk("midrst_fmap", 128'(o_fmap), 128'(0));
        step();
        reset   = 1'b0;
        i_valid = 1'b0;
        clear_q();
        fill_ramp();
        model_frame();
        drive_frame(0);
        idle(4);
        check_frame("midrst");

        // Two back-to-back ramp frames
        clear_q();
        fill_ramp();
        model_frame();
        model_frame();
        drive_frame(0);
        drive_frame(0);
        idle(4);
        check_frame("two");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
